// File: rtl/rv_pkg.sv
// Shared RV32 decode constants and immediate-format classification.
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_NONE = 3'd5
    } imm_type_e;

    // Map an opcode to the immediate format it carries.
    function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
        imm_type_e t;
        case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: t = IMM_I;
            OPC_STORE:                      t = IMM_S;
            OPC_BRANCH:                     t = IMM_B;
            OPC_LUI, OPC_AUIPC:             t = IMM_U;
            OPC_JAL:                        t = IMM_J;
            default:                        t = IMM_NONE;
        endcase
        return t;
    endfunction

    // Opcodes whose rd field is actually written back.
    function automatic logic writes_rd(input logic [6:0] opcode);
        logic w;
        case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_OP, OPC_LUI,
            OPC_AUIPC, OPC_JAL, OPC_JALR:   w = 1'b1;
            default:                        w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/id_ex_stage_imm_gen.sv
// Combinational RV32 immediate generator: instruction word -> sign-extended immediate.
module imm_gen
    import rv_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    imm_type_e imm_type_s;

    assign imm_type_s = imm_type_of(instr[6:0]);

    // Assemble the immediate according to the opcode's format.
    always_comb begin
        imm = 32'h0000_0000;
        case (imm_type_s)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'h000};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            default: imm = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: register-file addressing, WB bypass, immediate decode,
// load-use hazard detection with bubble insertion, and the EX pipeline register.
module id_ex_stage
    import rv_pkg::*;
(
    input  logic        sys_clk,
    input  logic        sys_reset,
    input  logic        id_valid_i,
    input  logic [31:0] id_instr_i,
    input  logic [31:0] id_pc_i,
    output logic [4:0]  RS_addr_o,
    output logic [4:0]  RT_addr_o,
    input  logic [31:0] RS_data_i,
    input  logic [31:0] RT_data_i,
    input  logic        wb_RegWrite_i,
    input  logic [4:0]  wb_RD_addr_i,
    input  logic [31:0] wb_RD_data_i,
    input  logic        flush_i,
    input  logic        ex_stall_i,
    output logic        stall_o,
    output logic        ex_valid_o,
    output logic [31:0] ex_pc_o,
    output logic [31:0] ex_rs_data_o,
    output logic [31:0] ex_rt_data_o,
    output logic [31:0] ex_imm_o,
    output logic [4:0]  ex_rd_addr_o,
    output logic [6:0]  ex_opcode_o,
    output logic [2:0]  ex_funct3_o,
    output logic [6:0]  ex_funct7_o,
    output logic        ex_mem_read_o,
    output logic        ex_reg_write_o,
    output logic [31:0] bubble_cnt_o
);

    // Decoded ID fields
    logic [6:0]  opcode_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [4:0]  rd_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic [31:0] imm_s;
    logic [31:0] rs_sel_s;
    logic [31:0] rt_sel_s;
    logic        rs1_used_s;
    logic        rs2_used_s;
    logic        hazard_s;

    // EX pipeline register
    logic        ex_valid_r;
    logic [31:0] ex_pc_r;
    logic [31:0] ex_rs_data_r;
    logic [31:0] ex_rt_data_r;
    logic [31:0] ex_imm_r;
    logic [4:0]  ex_rd_addr_r;
    logic [6:0]  ex_opcode_r;
    logic [2:0]  ex_funct3_r;
    logic [6:0]  ex_funct7_r;
    logic        ex_mem_read_r;
    logic        ex_reg_write_r;
    logic [31:0] bubble_cnt_r;

    assign opcode_s = id_instr_i[6:0];
    assign rd_s     = id_instr_i[11:7];
    assign funct3_s = id_instr_i[14:12];
    assign rs1_s    = id_instr_i[19:15];
    assign rs2_s    = id_instr_i[24:20];
    assign funct7_s = id_instr_i[31:25];

    assign RS_addr_o = rs1_s;
    assign RT_addr_o = rs2_s;

    imm_gen u_imm_gen (
        .instr (id_instr_i),
        .imm   (imm_s)
    );

    // Operand source: x0 is hard zero, then same-cycle write-back, then register file.
    function automatic logic [31:0] operand_sel(
        input logic [4:0]  addr,
        input logic [31:0] rf_data,
        input logic        wb_we,
        input logic [4:0]  wb_addr,
        input logic [31:0] wb_data
    );
        logic [31:0] v;
        if (addr == 5'd0) begin
            v = 32'h0000_0000;
        end else if (wb_we && (wb_addr == addr)) begin
            v = wb_data;
        end else begin
            v = rf_data;
        end
        return v;
    endfunction

    assign rs_sel_s = operand_sel(rs1_s, RS_data_i, wb_RegWrite_i, wb_RD_addr_i, wb_RD_data_i);
    assign rt_sel_s = operand_sel(rs2_s, RT_data_i, wb_RegWrite_i, wb_RD_addr_i, wb_RD_data_i);

    // Which source fields the ID instruction really reads (U/J formats reuse those bits as immediate).
    always_comb begin
        rs1_used_s = 1'b1;
        rs2_used_s = 1'b0;
        case (opcode_s)
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                rs1_used_s = 1'b0;
                rs2_used_s = 1'b0;
            end
            OPC_OP, OPC_STORE, OPC_BRANCH: begin
                rs1_used_s = 1'b1;
                rs2_used_s = 1'b1;
            end
            default: begin
                rs1_used_s = 1'b1;
                rs2_used_s = 1'b0;
            end
        endcase
    end

    // Load in EX whose destination is read by the ID instruction.
    always_comb begin
        hazard_s = 1'b0;
        if (ex_valid_r && ex_mem_read_r && (ex_rd_addr_r != 5'd0) && id_valid_i) begin
            hazard_s = ((ex_rd_addr_r == rs1_s) && rs1_used_s) ||
                       ((ex_rd_addr_r == rs2_s) && rs2_used_s);
        end else begin
            hazard_s = 1'b0;
        end
    end

    // IF/ID hold request; reset and flush both override any stall.
    always_comb begin
        stall_o = 1'b0;
        if (sys_reset || flush_i) begin
            stall_o = 1'b0;
        end else begin
            stall_o = ex_stall_i || hazard_s;
        end
    end

    // EX pipeline register: reset > flush > hold > bubble > capture.
    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            ex_valid_r     <= 1'b0;
            ex_pc_r        <= 32'h0000_0000;
            ex_rs_data_r   <= 32'h0000_0000;
            ex_rt_data_r   <= 32'h0000_0000;
            ex_imm_r       <= 32'h0000_0000;
            ex_rd_addr_r   <= 5'd0;
            ex_opcode_r    <= 7'd0;
            ex_funct3_r    <= 3'd0;
            ex_funct7_r    <= 7'd0;
            ex_mem_read_r  <= 1'b0;
            ex_reg_write_r <= 1'b0;
            bubble_cnt_r   <= 32'h0000_0000;
        end else if (flush_i) begin
            ex_valid_r     <= 1'b0;
            ex_mem_read_r  <= 1'b0;
            ex_reg_write_r <= 1'b0;
        end else if (ex_stall_i) begin
            ex_valid_r     <= ex_valid_r;
        end else if (hazard_s) begin
            ex_valid_r     <= 1'b0;
            ex_mem_read_r  <= 1'b0;
            ex_reg_write_r <= 1'b0;
            bubble_cnt_r   <= bubble_cnt_r + 32'd1;
        end else begin
            ex_valid_r     <= id_valid_i;
            ex_pc_r        <= id_pc_i;
            ex_rs_data_r   <= rs_sel_s;
            ex_rt_data_r   <= rt_sel_s;
            ex_imm_r       <= imm_s;
            ex_rd_addr_r   <= rd_s;
            ex_opcode_r    <= opcode_s;
            ex_funct3_r    <= funct3_s;
            ex_funct7_r    <= funct7_s;
            ex_mem_read_r  <= (opcode_s == OPC_LOAD);
            ex_reg_write_r <= writes_rd(opcode_s) && (rd_s != 5'd0);
        end
    end

    assign ex_valid_o     = ex_valid_r;
    assign ex_pc_o        = ex_pc_r;
    assign ex_rs_data_o   = ex_rs_data_r;
    assign ex_rt_data_o   = ex_rt_data_r;
    assign ex_imm_o       = ex_imm_r;
    assign ex_rd_addr_o   = ex_rd_addr_r;
    assign ex_opcode_o    = ex_opcode_r;
    assign ex_funct3_o    = ex_funct3_r;
    assign ex_funct7_o    = ex_funct7_r;
    assign ex_mem_read_o  = ex_mem_read_r;
    assign ex_reg_write_o = ex_reg_write_r;
    assign bubble_cnt_o   = bubble_cnt_r;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage sitting directly downstream of the register file. It drives the register-file read addresses from the ID instruction, and bypasses same-cycle write-back data into the operands. It decodes the immediate, detects load-use hazards, inserts bubbles, and registers everything into the EX-side pipeline register consumed by the ALU/branch unit.

## Interface
- No parameters; widths fixed (XLEN 32, 5-bit register addresses).
- sys_clk  in  1  rising-edge clock for all state.
- sys_reset  in  1  synchronous, active-high reset.
- id_valid_i  in  1  ID instruction valid.
- id_instr_i  in  32  ID instruction word.
- id_pc_i  in  32  ID instruction PC.
- RS_addr_o  out  5  rs1 field (instr[19:15]), combinational, to register file.
- RT_addr_o  out  5  rs2 field (instr[24:20]), combinational, to register file.
- RS_data_i  in  32  register-file rs1 read data.
- RT_data_i  in  32  register-file rs2 read data.
- wb_RegWrite_i  in  1  write-back write enable.
- wb_RD_addr_i  in  5  write-back destination.
- wb_RD_data_i  in  32  write-back data.
- flush_i  in  1  branch/jump taken in EX; kill ID and EX contents.
- ex_stall_i  in  1  EX cannot accept (multi-cycle op); hold stage.
- stall_o  out  1  combinational; IF/ID must hold its instruction.
- ex_valid_o  out  1  EX register valid.
- ex_pc_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o  out  32 each  registered operands.
- ex_rd_addr_o  out  5  destination (instr[11:7]).
- ex_opcode_o  out  7; ex_funct3_o  out  3; ex_funct7_o  out  7.
- ex_mem_read_o  out  1  opcode == LOAD.
- ex_reg_write_o  out  1  opcode writes rd and rd != 0.
- bubble_cnt_o  out  32  count of load-use bubbles inserted.

## Operation
- Per-cycle priority: sys_reset > flush_i > ex_stall_i > load-use hazard > normal capture.
- Reset: all registered outputs 0, including ex_valid_o and bubble_cnt_o.
- flush_i: ex_valid_o<=0, ex_mem_read_o<=0, ex_reg_write_o<=0; stall_o=0; the counter is unchanged.
- ex_stall_i (no flush): every EX register holds; stall_o=1.
- Load-use hazard is defined as ex_valid_o & ex_mem_read_o & ex_rd_addr_o!=0 & id_valid_i, plus a match.
  - Match: (ex_rd==rs1 & rs1 used) | (ex_rd==rs2 & rs2 used).
  - rs1 is used by all opcodes except LUI, AUIPC, JAL.
  - rs2 is used by OP, STORE, BRANCH only.
  - On a hazard, stall_o=1, the bubble is loaded (ex_valid_o<=0, ex_mem_read_o<=0, ex_reg_write_o<=0), and bubble_cnt_o increments.
- Normal capture: EX registers <= decoded ID fields; ex_valid_o <= id_valid_i.
- Operand select, per source:
  - Address 0 gives 0.
  - Else, if wb_RegWrite_i & wb_RD_addr_i==addr, wb_RD_data_i.
  - Else register-file data.
- Immediate, sign-extended to 32 bits:
  - I-type: LOAD, OP-IMM, JALR.
  - S-type: STORE.
  - B-type: BRANCH, bit0=0.
  - U-type: LUI/AUIPC, low 12 bits zero.
  - J-type: JAL, bit0=0.
  - Any other opcode gives 0.
- bubble_cnt_o wraps 0xFFFFFFFF -> 0.

## Timing
- Latency is one cycle: ID inputs at edge N appear on ex_* after edge N.
- A load-use costs exactly one bubble. On the next cycle the load has left EX, the hazard clears, and the held instruction is captured with the load result via the WB bypass or the register file.
- stall_o, RS_addr_o, and RT_addr_o are combinational from the current inputs and state; no registered path.
- Simultaneous hazard and ex_stall_i: hold wins; no bubble and no count.
- Reset asserted mid-stall clears state at that edge; stall_o=0 while sys_reset=1.

## Structure
- Shared package rv_pkg holds:
  - Opcode constants (LOAD 0000011, OP_IMM 0010011, STORE 0100011, BRANCH 1100011, OP 0110011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111).
  - The immediate-type enum (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE).
- One sub-module, imm_gen: combinational instr -> 32-bit immediate.
- The hazard detector and the pipeline register stay in id_ex_stage.

## Test plan
- Reset:
  - Stimulus: hold sys_reset 2 cycles with id_valid_i=1.
  - Required: all ex_* = 0, bubble_cnt_o=0, stall_o=0.
- Immediate decode and capture:
  - Stimulus: ADDI x1,x0,-5 (0xFFB00093).
  - Required, next cycle: ex_imm_o=0xFFFFFFFB, ex_rd_addr_o=1, ex_rs_data_o=0, ex_valid_o=1.
- WB bypass:
  - Stimulus: RS_data_i=0x11, wb_RegWrite_i=1, wb_RD_addr_i=rs1=5, wb_RD_data_i=0xABCD.
  - Required: ex_rs_data_o=0xABCD.
  - Same stimulus with wb_RD_addr_i=0 and rs1=0: required ex_rs_data_o=0.
- Load-use:
  - Stimulus: LW x3,0(x2) followed by ADD x4,x3,x1.
  - Required: one cycle with stall_o=1 and ex_valid_o=0 after it; ADD captured the following cycle; bubble_cnt_o=1.
  - Same sequence with LUI x4 as the consumer: required no stall.
- Flush vs hazard:
  - Stimulus: flush_i=1 during a load-use condition.
  - Required: ex_valid_o=0, stall_o=0, bubble_cnt_o unchanged.
- Hold:
  - Stimulus: ex_stall_i=1 for 3 cycles with a hazard present.
  - Required: ex_* unchanged, stall_o=1, bubble_cnt_o unchanged; resume captures correctly.
